// File: rtl/psram_channel_responder.sv
// Block-RAM stand-in for one PSRAM user-side channel: fixed-length write/read bursts with calibration delay.
// Optional PSRAM_RESP_PROTOCOL_CHECK_EN adds a sticky protocol_err flag for commands issued while busy.
module psram_channel_responder #(
  parameter int    ADDR_W       = 10,
  parameter int    BURST_WORDS  = 4,
  parameter int    RD_LATENCY   = 6,
  parameter int    TURNAROUND   = 2,
  parameter int    CALIB_CYCLES = 64,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        reset,
  output logic        init_calib,
  input  logic        cmd,
  input  logic        cmd_en,
  input  logic [20:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  data_mask,
  output logic [31:0] rd_data,
  output logic        rd_data_valid,
  output logic        busy,
  output logic        protocol_err
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = 16;
  localparam int BEAT_W = $clog2(BURST_WORDS + 1);

  typedef enum logic [2:0] {
    S_CALIB,
    S_IDLE,
    S_WRITE,
    S_RD_WAIT,
    S_RD_BURST,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                vld_q, vld_d;
  logic [31:0]         rd_data_q;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [31:0]         mem_wdata;
  logic [3:0]          mem_wmask;
  logic                rd_load;
  logic [ADDR_W-1:0]   rd_addr;

  logic [31:0]         mem [0:DEPTH-1];

  logic [ADDR_W-1:0]   word_in;
  logic                unused_addr;

  assign word_in     = addr[ADDR_W+1:2];
  assign unused_addr = ^{addr[1:0], addr[20:ADDR_W+2]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    vld_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = idx_q + ADDR_W'(beat_q);
    mem_wdata = wr_data;
    mem_wmask = data_mask;
    rd_load   = 1'b0;
    rd_addr   = idx_q + ADDR_W'(beat_q);
    case (state_q)
      S_CALIB: begin
        if (cnt_q == CNT_W'(CALIB_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (cmd_en) begin
          idx_d  = word_in;
          cnt_d  = '0;
          beat_d = '0;
          if (cmd) begin
            // Beat 0 of a write is taken straight off the command cycle.
            mem_we    = 1'b1;
            mem_waddr = word_in;
            if (BURST_WORDS == 1) begin
              state_d = (TURNAROUND == 0) ? S_IDLE : S_GAP;
            end else begin
              state_d = S_WRITE;
              beat_d  = BEAT_W'(1);
            end
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (beat_q == BEAT_W'(BURST_WORDS - 1)) begin
          state_d = (TURNAROUND == 0) ? S_IDLE : S_GAP;
          cnt_d   = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_RD_WAIT: begin
        // Registered RAM read lands one cycle after the load, so fire at latency-2.
        if (cnt_q == CNT_W'(RD_LATENCY - 2)) begin
          rd_load = 1'b1;
          rd_addr = idx_q;
          vld_d   = 1'b1;
          beat_d  = '0;
          state_d = S_RD_BURST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD_BURST: begin
        if (beat_q == BEAT_W'(BURST_WORDS - 1)) begin
          state_d = (TURNAROUND == 0) ? S_IDLE : S_GAP;
          cnt_d   = '0;
        end else begin
          beat_d  = beat_q + 1'b1;
          rd_load = 1'b1;
          rd_addr = idx_q + ADDR_W'(beat_q + 1'b1);
          vld_d   = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(TURNAROUND - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_CALIB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CALIB;
      cnt_q     <= '0;
      beat_q    <= '0;
      vld_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      vld_q   <= vld_d;
      if (rd_load) rd_data_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
  end

  // Reset suppresses the in-flight beat; earlier beats stay in the array.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (!mem_wmask[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign init_calib    = (state_q != S_CALIB);
  assign busy          = (state_q != S_IDLE);
  assign rd_data       = rd_data_q;
  assign rd_data_valid = vld_q;

`ifdef PSRAM_RESP_PROTOCOL_CHECK_EN
  logic        err_q;
  logic        cmd_en_prev_q;
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q         <= 1'b0;
      cmd_en_prev_q <= 1'b0;
      cyc_q         <= '0;
    end else begin
      cmd_en_prev_q <= cmd_en;
      cyc_q         <= cyc_q + 1'b1;
      if (cmd_en && (busy || cmd_en_prev_q)) begin
        err_q <= 1'b1;
        $error("psram_channel_responder: ignored cmd_en at cycle %0d", cyc_q);
      end
    end
  end

  assign protocol_err = err_q;
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_psram_channel_responder.sv
// Scoreboard bench for psram_channel_responder: table of masked-write cases plus hand-built timing sequences.
module tb_psram_channel_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd = 1'b0;
  logic        cmd_en = 1'b0;
  logic [20:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  data_mask = '0;
  logic        init_calib, rd_data_valid, busy, protocol_err;
  logic [31:0] rd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

`ifdef PSRAM_RESP_PROTOCOL_CHECK_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] init;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] expect_word;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [1024];

  psram_channel_responder dut (
    .clk          (clk),
    .reset        (reset),
    .init_calib   (init_calib),
    .cmd          (cmd),
    .cmd_en       (cmd_en),
    .addr         (addr),
    .wr_data      (wr_data),
    .data_mask    (data_mask),
    .rd_data      (rd_data),
    .rd_data_valid(rd_data_valid),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk1("rd_unexpected_valid", rd_data_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk1("wait_idle_timeout", busy, 1'b0);
  endtask

  task automatic write_burst(input logic [20:0] a, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3, input logic [3:0] m);
    logic [31:0] d[4];
    int w;
    d = '{d0, d1, d2, d3};
    w = int'(a[11:2]);
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      cmd_en    = (k == 0);
      cmd       = 1'b1;
      addr      = a;
      wr_data   = d[k];
      data_mask = m;
      for (int b = 0; b < 4; b++)
        if (!m[b]) ref_mem[(w + k) % 1024][8*b +: 8] = d[k][8*b +: 8];
      tick();
    end
    cmd_en    = 1'b0;
    cmd       = 1'b0;
    data_mask = 4'h0;
  endtask

  task automatic read_burst(input logic [20:0] a, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    wait_idle();
    cmd_en = 1'b1;
    cmd    = 1'b0;
    addr   = a;
    sb.push_back('{e0, cyc + 6});
    sb.push_back('{e1, cyc + 7});
    sb.push_back('{e2, cyc + 8});
    sb.push_back('{e3, cyc + 9});
    tick();
    cmd_en = 1'b0;
  endtask

  // Pulses reset for one cycle and follows the calibration window; inject drives a write during calib.
  task automatic reset_calib(input bit inject);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk);
      if (inject && i == 3) begin
        cmd_en = 1'b1; cmd = 1'b1; addr = 21'h10; wr_data = 32'hBAD0BAD0; data_mask = 4'h0;
      end
      if (inject && i == 4) begin
        cmd_en = 1'b0; cmd = 1'b0;
      end
      chk1("init_calib", init_calib, (i == 64));
      chk1("busy_calib", busy, (i != 64));
      if (i == 0) begin
        chk("reset_rd_data", rd_data, 32'h0);
        chk1("reset_rd_valid", rd_data_valid, 1'b0);
        chk1("reset_protocol_err", protocol_err, 1'b0);
      end
    end
    tick();
  endtask

  initial begin
    vec_t        tbl[4];
    logic [20:0] a;
    int          n;

    tbl[0] = '{32'hCAFEF00D, 32'hAABBCCDD, 4'b1010, 32'hCABBF0DD};
    tbl[1] = '{32'h13579BDF, 32'h02468ACE, 4'b1111, 32'h13579BDF};
    tbl[2] = '{32'h00000000, 32'hA5A5A5A5, 4'b0000, 32'hA5A5A5A5};
    tbl[3] = '{32'h12345678, 32'hFFFFFFFF, 4'b0110, 32'hFF3456FF};

    reset_calib(1'b0);

    write_burst(21'h000010, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'h0);
    chk1("wr_gap_busy0", busy, 1'b1);
    tick();
    chk1("wr_gap_busy1", busy, 1'b1);
    tick();
    chk1("wr_idle_after_gap", busy, 1'b0);
    read_burst(21'h000010, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

    for (int i = 0; i < 4; i++) begin
      a = 21'((100 + 4 * i) * 4);
      write_burst(a, tbl[i].init, tbl[i].init, tbl[i].init, tbl[i].init, 4'h0);
      write_burst(a, tbl[i].wdata, tbl[i].wdata, tbl[i].wdata, tbl[i].wdata, tbl[i].mask);
      read_burst(a, tbl[i].expect_word, tbl[i].expect_word, tbl[i].expect_word, tbl[i].expect_word);
    end

    write_burst(21'h000FF8, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 4'h0);
    read_burst(21'h000FF8, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004);
    read_burst(21'h000FF8, ref_mem[1022], ref_mem[1023], ref_mem[0], ref_mem[1]);

    // Commands right after a read accept and inside the turnaround gap must vanish.
    read_burst(21'h000010, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    chk1("busy_after_accept", busy, 1'b1);
    cmd_en = 1'b1; cmd = 1'b1; addr = 21'h10; wr_data = 32'hDEADBEEF; data_mask = 4'h0;
    tick();
    cmd_en = 1'b0; cmd = 1'b0;
    repeat (8) tick();
    chk1("busy_in_gap", busy, 1'b1);
    cmd_en = 1'b1; cmd = 1'b0; addr = 21'h20;
    tick();
    cmd_en = 1'b0;
    chk1("busy_gap_end", busy, 1'b1);
    tick();
    chk1("idle_after_read_gap", busy, 1'b0);
    chk1("protocol_err", protocol_err, EXP_PERR);
    read_burst(21'h000010, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

    // Reset lands on the cycle after the second read beat is shown.
    read_burst(21'h000010, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    repeat (6) tick();
    reset_calib(1'b1);
    read_burst(21'h000010, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    read_burst(21'h000190, tbl[0].expect_word, tbl[0].expect_word, tbl[0].expect_word,
               tbl[0].expect_word);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("scoreboard_drain", 32'(sb.size()), 32'h0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
